// File: rtl/vx_cache_tag_store_if.sv
// Request/response bundle between a cache bank pipeline and its tag store.
// The requester owns the request signals; the tag store answers combinationally in the same cycle.
interface vx_cache_tag_store_if #(
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int NUM_WAYS        = 4,
    parameter int TAGW            = 20
);
    logic                       stall;
    logic                       lookup;
    logic                       write;
    logic                       fill;
    logic                       fill_dirty;
    logic                       flush;
    logic [LINE_ADDR_WIDTH-1:0] addr;
    logic                       ready;
    logic                       tag_match;
    logic [NUM_WAYS-1:0]        way_sel;
    logic                       evict_valid;
    logic                       evict_dirty;
    logic [TAGW-1:0]            evict_tag;

    modport master (
        output stall, lookup, write, fill, fill_dirty, flush, addr,
        input  ready, tag_match, way_sel, evict_valid, evict_dirty, evict_tag
    );

    modport slave (
        input  stall, lookup, write, fill, fill_dirty, flush, addr,
        output ready, tag_match, way_sel, evict_valid, evict_dirty, evict_tag
    );
endinterface

// File: rtl/vx_cache_tag_store.sv
// Set-associative tag/valid/dirty store with invalid-first victim selection (cyclic or tree PLRU).
// Zero-latency combinational answers; state commits at the edge only when stall is low; busy-sweeps sets after reset.
module vx_cache_tag_store #(
    parameter int CACHE_SIZE      = 16384,
    parameter int LINE_SIZE       = 64,
    parameter int NUM_BANKS       = 1,
    parameter int NUM_WAYS        = 4,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int REPL_POLICY     = 1,
    parameter int WRITEBACK       = 1
) (
    input  logic                clk,
    input  logic                reset,
    vx_cache_tag_store_if.slave bus
);
    localparam int   SETS  = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS);
    localparam int   SEL   = $clog2(SETS);
    localparam int   TAGW  = LINE_ADDR_WIDTH - SEL;
    localparam int   SETW  = (SEL > 0) ? SEL : 1;
    localparam int   LVLS  = $clog2(NUM_WAYS);
    localparam int   WAYW  = (LVLS > 0) ? LVLS : 1;
    localparam int   PLRUW = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
    localparam int   PIDXW = (PLRUW > 1) ? $clog2(PLRUW) : 1;
    localparam logic WB    = (WRITEBACK != 0);

    typedef enum logic {INIT, READY} state_e;

    state_e              state_q, state_d;
    logic [SETW-1:0]     cnt_q, cnt_d;
    logic [NUM_WAYS-1:0] ptr_q, ptr_d;

    logic [NUM_WAYS-1:0] valid_q [SETS];
    logic [NUM_WAYS-1:0] dirty_q [SETS];
    logic [TAGW-1:0]     tag_q   [SETS][NUM_WAYS];
    logic [PLRUW-1:0]    plru_q  [SETS];

    logic [SETW-1:0]     set_idx;
    logic [TAGW-1:0]     req_tag;
    logic [NUM_WAYS-1:0] way_valid, way_dirty, hit_vec, hit_oh, inv_oh, policy_oh, victim_oh;
    logic [TAGW-1:0]     way_tag [NUM_WAYS];
    logic [PLRUW-1:0]    plru_rd, plru_touch;
    logic [WAYW-1:0]     plru_way, victim_idx, hit_idx, touch_way;
    logic                is_ready, do_flush, do_fill, do_lookup, lookup_hit;

    logic                row_we, tag_we;
    logic [SETW-1:0]     row_idx;
    logic [NUM_WAYS-1:0] valid_row_d, dirty_row_d;
    logic [PLRUW-1:0]    plru_row_d;

    assign set_idx = (SEL > 0) ? bus.addr[SETW-1:0] : '0;
    assign req_tag = bus.addr[LINE_ADDR_WIDTH-1:SEL];

    always_comb begin
        way_valid = valid_q[set_idx];
        way_dirty = dirty_q[set_idx];
        plru_rd   = plru_q[set_idx];
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_tag[w] = tag_q[set_idx][w];
            hit_vec[w] = way_valid[w] && (way_tag[w] == req_tag);
        end
    end

    // Lowest set bit of hit_vec, lowest clear bit of way_valid.
    assign hit_oh = hit_vec & (~hit_vec + NUM_WAYS'(1));
    assign inv_oh = ~way_valid & (way_valid + NUM_WAYS'(1));

    // Tree walk in heap order: node n has children 2n+1 (lower half) and 2n+2.
    always_comb begin
        int node;
        node = 0;
        for (int l = 0; l < LVLS; l++)
            node = 2 * node + 1 + int'(plru_rd[PIDXW'(node)]);
        plru_way = WAYW'(node - (NUM_WAYS - 1));
    end

    assign policy_oh = (NUM_WAYS == 1)    ? '1 :
                       (REPL_POLICY == 0) ? ptr_q : (NUM_WAYS'(1) << plru_way);
    assign victim_oh = (|inv_oh) ? inv_oh : policy_oh;

    always_comb begin
        victim_idx = '0;
        hit_idx    = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (victim_oh[w]) victim_idx = WAYW'(w);
            if (hit_oh[w])    hit_idx    = WAYW'(w);
        end
    end

    assign is_ready   = (state_q == READY);
    assign do_flush   = is_ready && bus.flush;
    assign do_fill    = is_ready && bus.fill && !bus.flush;
    assign do_lookup  = is_ready && bus.lookup && !bus.flush && !bus.fill;
    assign lookup_hit = do_lookup && (|hit_vec);
    assign touch_way  = do_fill ? victim_idx : hit_idx;

    // Every node on the touched way's path points to the opposite subtree.
    always_comb begin
        int   node;
        logic dir;
        node       = 0;
        dir        = 1'b0;
        plru_touch = plru_rd;
        for (int l = 0; l < LVLS; l++) begin
            dir                          = 1'(touch_way >> (LVLS - 1 - l));
            plru_touch[PIDXW'(node)]     = ~dir;
            node                         = 2 * node + 1 + int'(dir);
        end
    end

    always_comb begin
        row_we      = 1'b0;
        tag_we      = 1'b0;
        row_idx     = set_idx;
        valid_row_d = way_valid;
        dirty_row_d = way_dirty;
        plru_row_d  = plru_rd;
        if (state_q == INIT) begin
            row_we      = 1'b1;
            row_idx     = cnt_q;
            valid_row_d = '0;
            dirty_row_d = '0;
            plru_row_d  = '0;
        end else if (!bus.stall) begin
            if (do_flush) begin
                row_we      = 1'b1;
                valid_row_d = '0;
                dirty_row_d = '0;
            end else if (do_fill) begin
                row_we      = 1'b1;
                tag_we      = 1'b1;
                valid_row_d = way_valid | victim_oh;
                dirty_row_d = (way_dirty & ~victim_oh) | ((bus.fill_dirty && WB) ? victim_oh : '0);
                plru_row_d  = plru_touch;
            end else if (lookup_hit) begin
                row_we      = 1'b1;
                dirty_row_d = way_dirty | ((bus.write && WB) ? hit_oh : '0);
                plru_row_d  = plru_touch;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + SETW'(1);
            if (cnt_q == SETW'(SETS - 1)) state_d = READY;
        end
        if (!bus.stall) ptr_d = (ptr_q << 1) | (ptr_q >> (NUM_WAYS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ptr_q   <= NUM_WAYS'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Array contents need no reset: the INIT sweep clears valid/dirty/PLRU before any use.
    always_ff @(posedge clk) begin
        if (!reset && row_we) begin
            valid_q[row_idx] <= valid_row_d;
            dirty_q[row_idx] <= dirty_row_d;
            plru_q[row_idx]  <= plru_row_d;
        end
        if (!reset && tag_we) tag_q[set_idx][victim_idx] <= req_tag;
    end

    assign bus.ready       = is_ready;
    assign bus.tag_match   = lookup_hit;
    assign bus.way_sel     = do_fill ? victim_oh : (do_lookup ? hit_oh : '0);
    assign bus.evict_valid = do_fill && (|(way_valid & victim_oh));
    assign bus.evict_dirty = WB && do_fill && (|(way_dirty & victim_oh));
    assign bus.evict_tag   = do_fill ? way_tag[victim_idx] : '0;
endmodule

// File: tb/tb_vx_cache_tag_store.sv
// Drives a PLRU/writeback tag store and a cyclic/no-writeback one with identical stimulus;
// both are compared every cycle against a per-set array model plus directed expectations.
module tb_vx_cache_tag_store;
    localparam int AW = 26;
    localparam int NW = 4;
    localparam int TW = 22;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_cache_tag_store_if #(.LINE_ADDR_WIDTH(AW), .NUM_WAYS(NW), .TAGW(TW)) if_a ();
    vx_cache_tag_store_if #(.LINE_ADDR_WIDTH(AW), .NUM_WAYS(NW), .TAGW(TW)) if_b ();

    vx_cache_tag_store #(.CACHE_SIZE(4096), .LINE_SIZE(64), .NUM_BANKS(1), .NUM_WAYS(NW),
                         .LINE_ADDR_WIDTH(AW), .REPL_POLICY(1), .WRITEBACK(1))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    vx_cache_tag_store #(.CACHE_SIZE(4096), .LINE_SIZE(64), .NUM_BANKS(1), .NUM_WAYS(NW),
                         .LINE_ADDR_WIDTH(AW), .REPL_POLICY(0), .WRITEBACK(0))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));

    int tests = 0;
    int fails = 0;

    bit stall_r, lookup_r, write_r, fill_r, fdirty_r, flush_r;
    int set_r, tag_r;

    // Reference state: model 0 = tree PLRU + writeback, model 1 = cyclic, no writeback.
    bit mv [2][16][4];
    bit md [2][16][4];
    int mt [2][16][4];
    bit mb [2][16][2][2];   // [level][group]: 0 means the victim lies in the lower half
    bit mready;
    int mcnt;
    int ptrcnt;             // unstalled cycles since reset; cyclic victim = ptrcnt mod 4

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
        end
    endtask

    function automatic int victim(int m, int s);
        int g;
        g = 0;
        for (int w = 0; w < 4; w++) if (!mv[m][s][w]) return w;
        if (m == 1) return ptrcnt % 4;
        for (int l = 0; l < 2; l++) g = 2 * g + int'(mb[m][s][l][g]);
        return g;
    endfunction

    function automatic int hitway(int m, int s, int t);
        for (int w = 0; w < 4; w++) if (mv[m][s][w] && mt[m][s][w] == t) return w;
        return -1;
    endfunction

    task automatic touch(input int m, input int s, input int w);
        for (int l = 0; l < 2; l++) mb[m][s][l][w >> (2 - l)] = !(((w >> (1 - l)) & 1) != 0);
    endtask

    task automatic drive();
        logic [AW-1:0] a;
        a = AW'((tag_r << 4) | set_r);
        if_a.stall = stall_r; if_a.lookup = lookup_r; if_a.write = write_r;
        if_a.fill = fill_r; if_a.fill_dirty = fdirty_r; if_a.flush = flush_r; if_a.addr = a;
        if_b.stall = stall_r; if_b.lookup = lookup_r; if_b.write = write_r;
        if_b.fill = fill_r; if_b.fill_dirty = fdirty_r; if_b.flush = flush_r; if_b.addr = a;
    endtask

    task automatic chk_dut(input string nm, input int m, input logic rdy, input logic tm,
                           input logic [3:0] ws, input logic ev, input logic ed, input logic [TW-1:0] et);
        bit e_tm, e_ev, e_ed;
        bit [3:0] e_ws;
        int e_et, v, h;
        e_tm = 0; e_ws = 0; e_ev = 0; e_ed = 0; e_et = 0;
        if (mready && !flush_r) begin
            if (fill_r) begin
                v = victim(m, set_r);
                e_ws = 4'(1 << v);
                e_ev = mv[m][set_r][v];
                e_ed = md[m][set_r][v];
                e_et = mt[m][set_r][v];
            end else if (lookup_r) begin
                h = hitway(m, set_r, tag_r);
                if (h >= 0) begin e_tm = 1; e_ws = 4'(1 << h); end
            end
        end
        chk($sformatf("%s/%0d/ready", nm, m), 32'(rdy), 32'(mready));
        chk($sformatf("%s/%0d/tag_match", nm, m), 32'(tm), 32'(e_tm));
        chk($sformatf("%s/%0d/way_sel", nm, m), 32'(ws), 32'(e_ws));
        chk($sformatf("%s/%0d/evict_valid", nm, m), 32'(ev), 32'(e_ev));
        chk($sformatf("%s/%0d/evict_dirty", nm, m), 32'(ed), 32'(e_ed));
        chk($sformatf("%s/%0d/evict_tag", nm, m), 32'(et), 32'(e_et));
    endtask

    task automatic settle(input string nm);
        drive();
        #1;
        chk_dut(nm, 0, if_a.ready, if_a.tag_match, if_a.way_sel, if_a.evict_valid, if_a.evict_dirty, if_a.evict_tag);
        chk_dut(nm, 1, if_b.ready, if_b.tag_match, if_b.way_sel, if_b.evict_valid, if_b.evict_dirty, if_b.evict_tag);
    endtask

    task automatic model_update();
        int v, h;
        if (reset) begin
            mready = 0; mcnt = 0; ptrcnt = 0;
            for (int m = 0; m < 2; m++) for (int s = 0; s < 16; s++) mb[m][s] = '{default: 0};
            return;
        end
        if (!mready) begin
            for (int m = 0; m < 2; m++) begin
                for (int w = 0; w < 4; w++) begin mv[m][mcnt][w] = 0; md[m][mcnt][w] = 0; end
                mb[m][mcnt] = '{default: 0};
            end
            if (mcnt == 15) mready = 1;
            mcnt = (mcnt + 1) % 16;
        end else if (!stall_r) begin
            for (int m = 0; m < 2; m++) begin
                if (flush_r) begin
                    for (int w = 0; w < 4; w++) begin mv[m][set_r][w] = 0; md[m][set_r][w] = 0; end
                end else if (fill_r) begin
                    v = victim(m, set_r);
                    mv[m][set_r][v] = 1;
                    md[m][set_r][v] = fdirty_r && (m == 0);
                    mt[m][set_r][v] = tag_r;
                    touch(m, set_r, v);
                end else if (lookup_r) begin
                    h = hitway(m, set_r, tag_r);
                    if (h >= 0) begin
                        if (write_r) md[m][set_r][h] = (m == 0);
                        touch(m, set_r, h);
                    end
                end
            end
        end
        if (!stall_r) ptrcnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic op(input bit lk, input bit wr, input bit fl, input bit fd, input bit fs,
                      input int s, input int t);
        lookup_r = lk; write_r = wr; fill_r = fl; fdirty_r = fd; flush_r = fs; set_r = s; tag_r = t;
    endtask

    int nh_a, nh_b;

    initial begin
        stall_r = 0; reset = 1;
        op(1, 0, 0, 0, 0, 0, 0);
        mready = 0; mcnt = 0; ptrcnt = 0;
        drive();
        @(posedge clk);
        @(negedge clk);

        // Reset values, with lookup and then fill requested.
        settle("rst_lookup");
        chk("rst_ready", 32'(if_a.ready), 0);
        tick();
        op(0, 0, 1, 0, 0, 0, 0);
        settle("rst_fill");
        chk("rst_way_sel", 32'(if_a.way_sel), 0);
        tick();

        // Partial sweep, reset again, then the full sweep.
        reset = 0;
        op(1, 0, 0, 0, 0, 3, 5);
        for (int i = 0; i < 5; i++) begin settle("sweep_a"); tick(); end
        reset = 1;
        settle("mid_reset"); tick();
        reset = 0;
        for (int i = 0; i < 16; i++) begin
            settle("sweep");
            chk("sweep_not_ready", 32'(if_a.ready), 0);
            chk("sweep_no_match", 32'(if_a.tag_match), 0);
            tick();
        end
        settle("ready");
        chk("ready_after_16", 32'(if_a.ready), 1);
        tick();

        // Fill then hit.
        op(0, 0, 1, 0, 0, 3, 5);
        settle("fill_s3"); tick();
        op(1, 0, 0, 0, 0, 3, 5);
        settle("hit_s3");
        chk("hit_s3_match", 32'(if_a.tag_match), 1);
        chk("hit_s3_way", 32'(if_a.way_sel), 32'b0001);
        tick();

        // PLRU victim after filling set 2 and touching way 0.
        for (int i = 0; i < 4; i++) begin op(0, 0, 1, 0, 0, 2, 'h10 + i); settle("fill_s2"); tick(); end
        op(1, 0, 0, 0, 0, 2, 'h10); settle("hit_w0"); tick();
        op(0, 0, 1, 0, 0, 2, 'h14);
        settle("plru_victim");
        chk("plru_way_sel", 32'(if_a.way_sel), 32'b0100);
        chk("plru_evict_valid", 32'(if_a.evict_valid), 1);
        chk("plru_evict_dirty", 32'(if_a.evict_dirty), 0);
        tick();

        // Store hit on way 1, then steer the tree so way 1 is the victim.
        op(1, 1, 0, 0, 0, 2, 'h11); settle("store_w1"); tick();
        op(1, 0, 0, 0, 0, 2, 'h10); settle("hit_w0b"); tick();
        op(1, 0, 0, 0, 0, 2, 'h13); settle("hit_w3"); tick();
        op(0, 0, 1, 0, 0, 2, 'h15);
        settle("dirty_victim");
        chk("dirty_way_sel", 32'(if_a.way_sel), 32'b0010);
        chk("dirty_evict_dirty", 32'(if_a.evict_dirty), 1);
        chk("dirty_evict_tag", 32'(if_a.evict_tag), 'h11);
        chk("nowb_evict_dirty", 32'(if_b.evict_dirty), 0);
        tick();

        // Flush set 2.
        op(0, 0, 0, 0, 1, 2, 0); settle("flush_s2"); tick();
        for (int t = 'h10; t < 'h16; t++) begin
            op(1, 0, 0, 0, 0, 2, t);
            settle("post_flush");
            chk("flush_miss_a", 32'(if_a.tag_match), 0);
            chk("flush_miss_b", 32'(if_b.tag_match), 0);
            tick();
        end
        op(0, 0, 1, 0, 0, 2, 'h20);
        settle("post_flush_fill");
        chk("flush_victim_a", 32'(if_a.way_sel), 32'b0001);
        chk("flush_victim_b", 32'(if_b.way_sel), 32'b0001);
        tick();

        // Stalled fill into a full set: one write, pointer moves only when unstalled.
        for (int i = 0; i < 4; i++) begin op(0, 0, 1, 0, 0, 6, 'h30 + i); settle("fill_s6"); tick(); end
        op(0, 0, 1, 0, 0, 6, 'h34);
        stall_r = 1;
        for (int i = 0; i < 3; i++) begin settle("stall_fill"); tick(); end
        stall_r = 0;
        settle("unstall_fill"); tick();
        nh_a = 0; nh_b = 0;
        for (int t = 'h30; t < 'h35; t++) begin
            op(1, 0, 0, 0, 0, 6, t);
            settle("stall_probe");
            nh_a += int'(if_a.tag_match);
            nh_b += int'(if_b.tag_match);
            tick();
        end
        chk("one_write_a", 32'(nh_a), 4);
        chk("one_write_b", 32'(nh_b), 4);

        // Randomized traffic over a few sets and tags, including coinciding requests.
        for (int i = 0; i < 400; i++) begin
            stall_r  = ($urandom_range(0, 7) == 0);
            flush_r  = ($urandom_range(0, 19) == 0);
            fill_r   = ($urandom_range(0, 2) == 0);
            lookup_r = ($urandom_range(0, 2) != 0);
            write_r  = $urandom_range(0, 1);
            fdirty_r = $urandom_range(0, 1);
            set_r    = $urandom_range(0, 3) + 8;
            tag_r    = $urandom_range(0, 5);
            settle("rand");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
